// File: rtl/sad_min_search_pkg.sv
// Shared definitions for the SAD minimum-search block: FSM state encoding,
// default geometry/widths shared with the abs-diff ALU and core top, and a counter-width helper.
package sad_min_search_pkg;

  localparam int unsigned DEF_BLOCK_PIXELS = 16;
  localparam int unsigned DEF_NUM_CAND     = 64;
  localparam int unsigned DEF_AD_W         = 32;
  localparam int unsigned DEF_ACC_W        = 32;
  localparam int unsigned DEF_IDX_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } sad_state_e;

  // Bits needed to count 0..n inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sad_accumulator.sv
// Per-candidate SAD accumulator: sums BLOCK_PIXELS zero-extended AD samples.
// Build option SAD_SATURATE_EN makes the sum clamp at all ones instead of wrapping.
module sad_accumulator
  import sad_min_search_pkg::*;
#(
  parameter int unsigned BLOCK_PIXELS = DEF_BLOCK_PIXELS,
  parameter int unsigned AD_W         = DEF_AD_W,
  parameter int unsigned ACC_W        = DEF_ACC_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [AD_W-1:0]  ad,
  output logic [ACC_W-1:0] acc,
  output logic             blk_last
);

  localparam int unsigned PIX_W = cnt_width(BLOCK_PIXELS);
  localparam int unsigned SUM_W = ACC_W + 1;

  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] add_val;

`ifdef SAD_SATURATE_EN
  logic [SUM_W-1:0] sum_ext;
  assign sum_ext = SUM_W'(acc_q) + SUM_W'(ad);
  // Carry out of the accumulator width pins the result at all ones.
  assign add_val = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
  assign add_val = acc_q + ACC_W'(ad);
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    acc_d     = acc_q;
    pix_cnt_d = pix_cnt_q;
    if (clr) begin
      acc_d     = '0;
      pix_cnt_d = '0;
    end else if (add_en) begin
      acc_d     = add_val;
      pix_cnt_d = pix_cnt_q + PIX_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      acc_q     <= '0;
      pix_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign acc      = acc_q;
  assign blk_last = add_en && !clr && (pix_cnt_q == PIX_W'(BLOCK_PIXELS - 1));

endmodule

// File: rtl/sad_min_search.sv
// SAD minimum search: accumulates one SAD per candidate window and tracks the
// smallest SAD and its index across NUM_CAND candidates. Option: SAD_SATURATE_EN.
module sad_min_search
  import sad_min_search_pkg::*;
#(
  parameter int unsigned BLOCK_PIXELS = DEF_BLOCK_PIXELS,
  parameter int unsigned NUM_CAND     = DEF_NUM_CAND,
  parameter int unsigned AD_W         = DEF_AD_W,
  parameter int unsigned ACC_W        = DEF_ACC_W,
  parameter int unsigned IDX_W        = DEF_IDX_W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             AD_Valid,
  input  logic [AD_W-1:0]  AD,
  output logic             AD_Ready,
  output logic             Cand_Valid,
  output logic [ACC_W-1:0] Cand_SAD,
  output logic [IDX_W-1:0] Cand_Idx,
  output logic [ACC_W-1:0] Min_SAD,
  output logic [IDX_W-1:0] Min_Idx,
  output logic             Busy,
  output logic             Done
);

  sad_state_e       state_q, state_d;
  logic [IDX_W-1:0] cand_cnt_q, cand_cnt_d;
  logic [ACC_W-1:0] min_sad_q, min_sad_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;

  logic             acc_clr;
  logic             acc_add;
  logic [ACC_W-1:0] acc;
  logic             blk_last;
  logic             restart;
  logic             last_cand;

  sad_accumulator #(
    .BLOCK_PIXELS (BLOCK_PIXELS),
    .AD_W         (AD_W),
    .ACC_W        (ACC_W)
  ) u_acc (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr      (acc_clr),
    .add_en   (acc_add),
    .ad       (AD),
    .acc      (acc),
    .blk_last (blk_last)
  );

  // Start is honoured everywhere except the DONE cycle, where it is dropped.
  assign restart   = Start && (state_q != ST_DONE);
  assign last_cand = (cand_cnt_q == IDX_W'(NUM_CAND - 1));

  always_comb begin
    state_d    = state_q;
    cand_cnt_d = cand_cnt_q;
    min_sad_d  = min_sad_q;
    min_idx_d  = min_idx_q;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_ACCUM: begin
        acc_add = AD_Valid;
        if (blk_last) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        // Strict compare: a tie keeps the earlier candidate.
        if (acc < min_sad_q) begin
          min_sad_d = acc;
          min_idx_d = cand_cnt_q;
        end
        if (last_cand) begin
          state_d = ST_DONE;
        end else begin
          cand_cnt_d = cand_cnt_q + IDX_W'(1);
          acc_clr    = 1'b1;
          state_d    = ST_ACCUM;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A new search overrides whatever the current state decided.
    if (restart) begin
      state_d    = ST_ACCUM;
      cand_cnt_d = '0;
      min_sad_d  = '1;
      min_idx_d  = '0;
      acc_clr    = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      cand_cnt_q <= '0;
      min_sad_q  <= '1;
      min_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cand_cnt_q <= cand_cnt_d;
      min_sad_q  <= min_sad_d;
      min_idx_q  <= min_idx_d;
    end
  end

  assign AD_Ready   = (state_q == ST_ACCUM);
  assign Cand_Valid = (state_q == ST_COMPARE);
  assign Cand_SAD   = acc;
  assign Cand_Idx   = cand_cnt_q;
  assign Min_SAD    = min_sad_q;
  assign Min_Idx    = min_idx_q;
  assign Busy       = (state_q == ST_ACCUM) || (state_q == ST_COMPARE);
  assign Done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search: table-driven searches with a candidate
// scoreboard, plus restart, reset-abort and 8-bit overflow sequences.
module tb_sad_min_search;

  localparam int BP    = 4;
  localparam int NC    = 3;
  localparam int AD_W  = 8;
  localparam int ACC_W = 10;
  localparam int IDX_W = 2;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Start;
  logic             AD_Valid;
  logic [AD_W-1:0]  AD;
  logic             AD_Ready;
  logic             Cand_Valid;
  logic [ACC_W-1:0] Cand_SAD;
  logic [IDX_W-1:0] Cand_Idx;
  logic [ACC_W-1:0] Min_SAD;
  logic [IDX_W-1:0] Min_Idx;
  logic             Busy;
  logic             Done;

  logic       s_start, s_valid, s_ready, s_cv, s_busy, s_done;
  logic [7:0] s_ad, s_cand_sad, s_min_sad;
  logic [0:0] s_cand_idx, s_min_idx;

  always #5 Clk = ~Clk;

  sad_min_search #(
    .BLOCK_PIXELS (BP), .NUM_CAND (NC), .AD_W (AD_W), .ACC_W (ACC_W), .IDX_W (IDX_W)
  ) dut (
    .Clk (Clk), .Rst (Rst), .Start (Start), .AD_Valid (AD_Valid), .AD (AD),
    .AD_Ready (AD_Ready), .Cand_Valid (Cand_Valid), .Cand_SAD (Cand_SAD),
    .Cand_Idx (Cand_Idx), .Min_SAD (Min_SAD), .Min_Idx (Min_Idx),
    .Busy (Busy), .Done (Done)
  );

  sad_min_search #(
    .BLOCK_PIXELS (2), .NUM_CAND (1), .AD_W (8), .ACC_W (8), .IDX_W (1)
  ) dut_sat (
    .Clk (Clk), .Rst (Rst), .Start (s_start), .AD_Valid (s_valid), .AD (s_ad),
    .AD_Ready (s_ready), .Cand_Valid (s_cv), .Cand_SAD (s_cand_sad),
    .Cand_Idx (s_cand_idx), .Min_SAD (s_min_sad), .Min_Idx (s_min_idx),
    .Busy (s_busy), .Done (s_done)
  );

  typedef struct {
    logic [ACC_W-1:0] sad;
    logic [IDX_W-1:0] idx;
  } cand_t;

  typedef struct {
    logic [AD_W-1:0]  ad [NC][BP];
    logic [ACC_W-1:0] exp_min;
    logic [IDX_W-1:0] exp_idx;
    bit               gaps;
  } search_t;

  search_t tbl [4];
  cand_t   exp_q [$];
  cand_t   mon_e;
  int      n_checks = 0;
  int      n_fail   = 0;
  int      done_cnt = 0;
  bit      prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Candidate scoreboard and Done-latency monitor.
  always @(negedge Clk) begin
    if (Rst) begin
      prev_last = 1'b0;
    end else begin
      if (Cand_Valid) begin
        check("ad_ready_in_compare", 32'(AD_Ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_cand_valid", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("cand_sad", 32'(Cand_SAD), 32'(mon_e.sad));
          check("cand_idx", 32'(Cand_Idx), 32'(mon_e.idx));
        end
      end
      if (Done) begin
        done_cnt++;
        check("done_after_last_cand", 32'(prev_last), 32'd1);
      end
      prev_last = Cand_Valid && (Cand_Idx == IDX_W'(NC - 1));
    end
  end

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic send_sample(input logic [AD_W-1:0] v, input bit gaps);
    int  t = 0;
    bit  sent = 1'b0;
    while (!sent) begin
      @(negedge Clk);
      t++;
      if (t > 200) begin
        check("sample_accept_timeout", 32'd0, 32'd1);
        return;
      end
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        AD_Valid = 1'b0;
      end else begin
        AD       = v;
        AD_Valid = 1'b1;
        sent     = AD_Ready;
      end
    end
  endtask

  task automatic run_search(input int k, input bit start_in_done);
    int    t;
    cand_t e;
    pulse_start();
    for (int c = 0; c < NC; c++) begin
      e.sad = '0;
      e.idx = IDX_W'(c);
      for (int p = 0; p < BP; p++) begin
        e.sad = e.sad + ACC_W'(tbl[k].ad[c][p]);
        if (p == BP - 1) exp_q.push_back(e);
        send_sample(tbl[k].ad[c][p], tbl[k].gaps);
      end
    end
    @(negedge Clk);
    AD_Valid = 1'b0;
    t = 0;
    while (!Done && t < 20) begin
      @(negedge Clk);
      t++;
    end
    check($sformatf("done_seen_%0d", k), 32'(Done), 32'd1);
    check($sformatf("min_sad_%0d", k), 32'(Min_SAD), 32'(tbl[k].exp_min));
    check($sformatf("min_idx_%0d", k), 32'(Min_Idx), 32'(tbl[k].exp_idx));
    if (start_in_done) begin
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      check("start_in_done_ignored", 32'(Busy), 32'd0);
      check("min_held_after_done", 32'(Min_SAD), 32'(tbl[k].exp_min));
    end
    @(negedge Clk);
  endtask

  initial begin
    int d0;
    int t;
    logic [7:0] exp_sat;

    tbl[0].ad = '{'{8'd1, 8'd1, 8'd1, 8'd1}, '{8'd0, 8'd0, 8'd1, 8'd0}, '{8'd2, 8'd2, 8'd2, 8'd2}};
    tbl[0].exp_min = 10'd1;  tbl[0].exp_idx = 2'd1; tbl[0].gaps = 1'b0;
    tbl[1].ad = '{'{8'd2, 8'd1, 8'd1, 8'd1}, '{8'd1, 8'd1, 8'd1, 8'd2}, '{8'd3, 8'd2, 8'd1, 8'd1}};
    tbl[1].exp_min = 10'd5;  tbl[1].exp_idx = 2'd0; tbl[1].gaps = 1'b0;
    tbl[2] = tbl[0];
    tbl[2].gaps = 1'b1;
    tbl[3].ad = '{'{8'd10, 8'd20, 8'd30, 8'd40}, '{8'd255, 8'd255, 8'd255, 8'd255}, '{8'd0, 8'd0, 8'd0, 8'd0}};
    tbl[3].exp_min = 10'd0;  tbl[3].exp_idx = 2'd2; tbl[3].gaps = 1'b1;

    Rst = 1'b1; Start = 1'b0; AD_Valid = 1'b0; AD = '0;
    s_start = 1'b0; s_valid = 1'b0; s_ad = '0;
    repeat (3) @(negedge Clk);
    check("rst_ad_ready",   32'(AD_Ready),   32'd0);
    check("rst_cand_valid", 32'(Cand_Valid), 32'd0);
    check("rst_busy",       32'(Busy),       32'd0);
    check("rst_done",       32'(Done),       32'd0);
    check("rst_cand_sad",   32'(Cand_SAD),   32'd0);
    check("rst_min_sad",    32'(Min_SAD),    32'd1023);
    check("rst_min_idx",    32'(Min_Idx),    32'd0);
    Rst = 1'b0;

    // Table-driven searches: basic, tie, 50% valid gaps with Start in DONE, mixed.
    for (int k = 0; k < 4; k++) run_search(k, k == 2);

    // Restart in the middle of candidate 1: partial results are discarded.
    pulse_start();
    exp_q.push_back('{sad: 10'd4, idx: 2'd0});
    for (int p = 0; p < BP; p++) send_sample(8'd1, 1'b0);
    send_sample(8'd7, 1'b0);
    send_sample(8'd7, 1'b0);
    @(negedge Clk);
    AD_Valid = 1'b0;
    d0 = done_cnt;
    run_search(0, 1'b0);
    repeat (3) @(negedge Clk);
    check("restart_single_done", 32'(done_cnt - d0), 32'd1);

    // Reset in ACCUM aborts the search without a Done pulse.
    pulse_start();
    send_sample(8'd9, 1'b0);
    send_sample(8'd9, 1'b0);
    @(negedge Clk);
    AD_Valid = 1'b0;
    Rst = 1'b1;
    d0 = done_cnt;
    @(negedge Clk);
    check("abort_ad_ready", 32'(AD_Ready),   32'd0);
    check("abort_busy",     32'(Busy),       32'd0);
    check("abort_cand_sad", 32'(Cand_SAD),   32'd0);
    check("abort_cand_idx", 32'(Cand_Idx),   32'd0);
    check("abort_min_sad",  32'(Min_SAD),    32'd1023);
    check("abort_min_idx",  32'(Min_Idx),    32'd0);
    Rst = 1'b0;
    repeat (6) @(negedge Clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle",    32'(Busy),          32'd0);

    // 8-bit accumulator overflow: 200 + 100.
`ifdef SAD_SATURATE_EN
    exp_sat = 8'd255;
`else
    exp_sat = 8'd44;
`endif
    @(negedge Clk);
    s_start = 1'b1;
    @(negedge Clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    s_ad    = 8'd200;
    check("sat_ready", 32'(s_ready), 32'd1);
    @(negedge Clk);
    s_ad = 8'd100;
    @(negedge Clk);
    s_valid = 1'b0;
    t = 0;
    while (!s_cv && t < 10) begin
      @(negedge Clk);
      t++;
    end
    check("sat_cand_valid", 32'(s_cv),       32'd1);
    check("sat_cand_sad",   32'(s_cand_sad), 32'(exp_sat));
    check("sat_cand_idx",   32'(s_cand_idx), 32'd0);
    @(negedge Clk);
    check("sat_done",       32'(s_done),     32'd1);
    check("sat_min_sad",    32'(s_min_sad),  32'(exp_sat));

    repeat (2) @(negedge Clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
